// File: rtl/sincos_double.sv
// Angle-to-Cartesian helper: iterative rotation-mode CORDIC on a Q3.10 angle,
// with cos/sin normalized to IEEE-754 doubles.
module sincos_double #(
    parameter int unsigned ITER = 16,
    parameter int unsigned FRAC = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [12:0] angle,
    output logic [63:0] cos_out,
    output logic [63:0] sin_out,
    output logic        DataReady,
    output logic        busy
);
    localparam int unsigned W   = FRAC + 3;
    localparam int unsigned IW  = (ITER > 1) ? $clog2(ITER) : 1;
    localparam int unsigned SHL = (FRAC >= 10) ? FRAC - 10 : 0;
    localparam int unsigned SHR = (FRAC >= 10) ? 0 : 10 - FRAC;

    // Round a real constant to FRAC fraction bits (real-to-integer casts round to nearest).
    function automatic longint fix(input real r);
        return longint'(r * (2.0 ** FRAC));
    endfunction

    // atan(2^-i) via its Taylor series; i = 0 is pi/4 where the series converges too slowly.
    function automatic longint atan_fix(input int i);
        real x;
        real t;
        real s;
        s = 0.0;
        if (i == 0) begin
            s = 0.7853981633974483;
        end else begin
            x = 1.0 / (2.0 ** i);
            t = x;
            for (int k = 0; k < 60; k++) begin
                s = (k % 2 == 0) ? s + t / real'(2 * k + 1) : s - t / real'(2 * k + 1);
                t = t * x * x;
            end
        end
        return fix(s);
    endfunction

    // Exact fixed-point to double; W <= 53 keeps every magnitude inside the mantissa.
    function automatic logic [63:0] to_double(input logic signed [W-1:0] v);
        logic [W-1:0]  m;
        logic [51:0]   mant;
        logic [63:0]   res;
        int            p;
        res = 64'h0;
        if (v != '0) begin
            m = W'(v[W-1] ? -v : v);
            p = 0;
            for (int b = 0; b < int'(W); b++) begin
                if (m[b]) p = b;
            end
            mant = 52'(53'(m) << (52 - p));
            res  = {v[W-1], 11'(1023 + p - int'(FRAC)), mant};
        end
        return res;
    endfunction

    localparam logic signed [W-1:0] K_F       = W'(fix(0.6072529350));
    localparam logic signed [W-1:0] PI_F      = W'(fix(3.141592653589793));
    localparam logic signed [W-1:0] HALF_PI_F = W'(fix(1.5707963267948966));

    logic signed [W-1:0] atan_lut [ITER];
    for (genvar g = 0; g < int'(ITER); g++) begin : g_lut
        localparam logic signed [W-1:0] ATAN_G = W'(atan_fix(g));
        assign atan_lut[g] = ATAN_G;
    end

    typedef enum logic [1:0] {IDLE, ROTATE, CONVERT} state_t;

    state_t              state;
    logic signed [W-1:0] x, y, z;
    logic [IW-1:0]       i;
    logic                neg;

    logic signed [63:0]  a64;
    logic signed [W-1:0] z_in, z_fold;
    logic                neg_fold;
    logic signed [W-1:0] xs, ys, x_nx, y_nx, z_nx, xc, yc;

    // Angle capture and fold into [-pi/2, pi/2], remembering the half-turn as a sign flip.
    always_comb begin
        a64      = 64'(signed'(angle));
        z_in     = W'((a64 <<< SHL) >>> SHR);
        z_fold   = z_in;
        neg_fold = 1'b0;
        if (z_in > HALF_PI_F) begin
            z_fold   = z_in - PI_F;
            neg_fold = 1'b1;
        end else if (z_in < -HALF_PI_F) begin
            z_fold   = z_in + PI_F;
            neg_fold = 1'b1;
        end
    end

    // One CORDIC micro-rotation, plus the post-fold sign correction.
    always_comb begin
        xs = x >>> i;
        ys = y >>> i;
        if (!z[W-1]) begin
            x_nx = x - ys;
            y_nx = y + xs;
            z_nx = z - atan_lut[i];
        end else begin
            x_nx = x + ys;
            y_nx = y - xs;
            z_nx = z + atan_lut[i];
        end
        xc = neg ? -x : x;
        yc = neg ? -y : y;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            x         <= '0;
            y         <= '0;
            z         <= '0;
            i         <= '0;
            neg       <= 1'b0;
            cos_out   <= 64'h0;
            sin_out   <= 64'h0;
            DataReady <= 1'b0;
            busy      <= 1'b0;
        end else begin
            DataReady <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        z     <= z_fold;
                        neg   <= neg_fold;
                        x     <= K_F;
                        y     <= '0;
                        i     <= '0;
                        busy  <= 1'b1;
                        state <= ROTATE;
                    end
                end
                ROTATE: begin
                    x <= x_nx;
                    y <= y_nx;
                    z <= z_nx;
                    i <= i + IW'(1);
                    if (i == IW'(ITER - 1)) state <= CONVERT;
                end
                CONVERT: begin
                    cos_out   <= to_double(xc);
                    sin_out   <= to_double(yc);
                    DataReady <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
